// File: rtl/twdl_cta_pkg.sv
// rtl/twdl_cta_pkg.sv - shared widths, FSM states and delay-line element for the twiddle index generator
package twdl_cta_pkg;

   localparam int W_DATA_IN_DEF   = 12;
   localparam int W_DATA_DEF      = 16;
   localparam int COEFF_DELAY_DEF = 24;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic                         valid;
      logic                         sop;
      logic                         eop;
      logic signed [W_DATA_DEF-1:0] re;
      logic signed [W_DATA_DEF-1:0] im;
   } sample_t;

endpackage

// File: rtl/twdl_delay_line.sv
// rtl/twdl_delay_line.sv - fixed-depth shift register, advances every cycle, async clear
module twdl_delay_line #(
   parameter int DEPTH = 25,
   parameter int WIDTH = 35
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/twdl_index_gen_cta.sv
// rtl/twdl_index_gen_cta.sv - r*c / N1*N2 index generator with matching sample delay
module twdl_index_gen_cta
   import twdl_cta_pkg::*;
#(
   parameter int wDataIn     = W_DATA_IN_DEF,
   parameter int wData       = W_DATA_DEF,
   parameter int COEFF_DELAY = COEFF_DELAY_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [wDataIn-1:0] cfg_n1,
   input  logic [wDataIn-1:0] cfg_n2,
   input  logic               in_valid,
   input  logic               in_sop,
   input  logic               in_eop,
   input  logic [wData-1:0]   in_real,
   input  logic [wData-1:0]   in_imag,
   output logic [wDataIn-1:0] numerator,
   output logic [wDataIn-1:0] denominator,
   output logic               out_valid,
   output logic               out_sop,
   output logic               out_eop,
   output logic [wData-1:0]   out_real,
   output logic [wData-1:0]   out_imag,
   output logic               err_frame
);

   localparam logic [wDataIn-1:0] ONE = wDataIn'(1);

   state_e             state_q, state_d;
   logic [wDataIn-1:0] n1_q, n1_d, n2_q, n2_d;
   logic [wDataIn-1:0] c_q, c_d, r_q, r_d, acc_q, acc_d;
   logic [wDataIn-1:0] num_q, num_d, den_q, den_d;
   logic               err_q, err_d;
   logic               last_col, last_row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n1_q    <= '0;
         n2_q    <= '0;
         c_q     <= '0;
         r_q     <= '0;
         acc_q   <= '0;
         num_q   <= '0;
         den_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n1_q    <= n1_d;
         n2_q    <= n2_d;
         c_q     <= c_d;
         r_q     <= r_d;
         acc_q   <= acc_d;
         num_q   <= num_d;
         den_q   <= den_d;
         err_q   <= err_d;
      end
   end

   // c/r/acc hold the index of the next expected sample; acc tracks r*c by repeated addition
   always_comb begin
      state_d  = state_q;
      n1_d     = n1_q;
      n2_d     = n2_q;
      c_d      = c_q;
      r_d      = r_q;
      acc_d    = acc_q;
      num_d    = num_q;
      den_d    = den_q;
      err_d    = 1'b0;
      last_col = (c_q == n2_q - ONE);
      last_row = (r_q == n1_q - ONE);
      if (in_valid) begin
         if (in_sop) begin
            state_d = in_eop ? IDLE : RUN;
            n1_d    = cfg_n1;
            n2_d    = cfg_n2;
            den_d   = cfg_n1 * cfg_n2;
            num_d   = '0;
            c_d     = ONE;
            r_d     = '0;
            acc_d   = '0;
            err_d   = (state_q == RUN) || in_eop;
         end else if (state_q == RUN) begin
            num_d = acc_q;
            if (in_eop || (last_col && last_row)) begin
               state_d = IDLE;
               err_d   = !(in_eop && last_col && last_row);
            end else if (last_col) begin
               c_d   = '0;
               r_d   = r_q + ONE;
               acc_d = '0;
            end else begin
               c_d   = c_q + ONE;
               acc_d = acc_q + r_q;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign numerator   = num_q;
   assign denominator = den_q;
   assign err_frame   = err_q;

   sample_t dl_in, dl_out;

   always_comb begin
      dl_in       = '0;
      dl_in.valid = in_valid;
      dl_in.sop   = in_sop;
      dl_in.eop   = in_eop;
      dl_in.re    = in_real;
      dl_in.im    = in_imag;
   end

   // one extra stage covers the registered index, so data lines up with the coefficient
   twdl_delay_line #(
      .DEPTH (COEFF_DELAY + 1),
      .WIDTH ($bits(sample_t))
   ) u_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (dl_in),
      .dout_o (dl_out)
   );

   assign out_valid = dl_out.valid;
   assign out_sop   = dl_out.sop;
   assign out_eop   = dl_out.eop;
   assign out_real  = dl_out.re;
   assign out_imag  = dl_out.im;

endmodule

// File: tb/tb_twdl_index_gen_cta.sv
// tb/tb_twdl_index_gen_cta.sv - randomized self-checking bench against a frame-index reference model
module tb_twdl_index_gen_cta;

   localparam int W   = 12;
   localparam int D   = 16;
   localparam int LAT = 25;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] cfg_n1, cfg_n2;
   logic         in_valid, in_sop, in_eop;
   logic [D-1:0] in_real, in_imag;
   logic [W-1:0] numerator, denominator;
   logic         out_valid, out_sop, out_eop, err_frame;
   logic [D-1:0] out_real, out_imag;

   always #5 clk = ~clk;

   twdl_index_gen_cta dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_n1      (cfg_n1),
      .cfg_n2      (cfg_n2),
      .in_valid    (in_valid),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_real     (in_real),
      .in_imag     (in_imag),
      .numerator   (numerator),
      .denominator (denominator),
      .out_valid   (out_valid),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_real    (out_real),
      .out_imag    (out_imag),
      .err_frame   (err_frame)
   );

   typedef struct {
      logic         v, s, e;
      logic [D-1:0] re, im;
   } smp_t;

   smp_t hist[$];
   int   total = 0;
   int   bad   = 0;

   bit m_run;
   bit m_err;
   int m_k, m_n1, m_n2, m_num, m_den;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      smp_t z;
      z = '{1'b0, 1'b0, 1'b0, '0, '0};
      m_run = 0; m_err = 0; m_k = 0; m_n1 = 0; m_n2 = 0; m_num = 0; m_den = 0;
      hist.delete();
      for (int i = 0; i < LAT - 1; i++) hist.push_back(z);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_num"}, 32'(numerator), 0);
      chk({tag, "_den"}, 32'(denominator), 0);
      chk({tag, "_err"}, 32'(err_frame), 0);
      chk({tag, "_oval"}, 32'({out_valid, out_sop, out_eop}), 0);
      chk({tag, "_odata"}, {out_real, out_imag}, 0);
   endtask

   // One input cycle: apply, clock, advance model, compare everything
   task automatic send(input bit v, input bit s, input bit e);
      smp_t x;
      int   n1, n2, last;
      in_valid = v; in_sop = s; in_eop = e;
      in_real  = D'($urandom); in_imag = D'($urandom);
      x  = '{v, s, e, in_real, in_imag};
      n1 = int'(cfg_n1); n2 = int'(cfg_n2);
      @(posedge clk); #1;
      m_err = 0;
      if (v) begin
         if (s) begin
            m_err = m_run || e;
            m_run = !e;
            m_n1 = n1; m_n2 = n2;
            m_den = (n1 * n2) % 4096;
            m_num = 0; m_k = 1;
         end else if (m_run) begin
            m_num = (m_k / m_n2) * (m_k % m_n2);
            last  = m_n1 * m_n2 - 1;
            if (e || m_k == last) begin
               m_err = !(e && m_k == last);
               m_run = 0;
            end else begin
               m_k++;
            end
         end else begin
            m_err = 1;
         end
      end
      hist.push_back(x);
      chk("numerator", 32'(numerator), m_num);
      chk("denominator", 32'(denominator), m_den);
      chk("err_frame", 32'(err_frame), 32'(m_err));
      chk("out_flags", 32'({out_valid, out_sop, out_eop}), 32'({hist[0].v, hist[0].s, hist[0].e}));
      chk("out_data", {out_real, out_imag}, {hist[0].re, hist[0].im});
      void'(hist.pop_front());
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_zero("reset");
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // gap: 0 none, 1 alternate idle cycles, 2 random idles
   task automatic frame(input int n1, input int n2, input int gap);
      for (int k = 0; k < n1 * n2; k++) begin
         if (gap == 1 && k > 0) send(0, 0, 0);
         while (gap == 2 && $urandom_range(99, 0) < 30) send(0, 0, 0);
         if (k == 0) begin
            cfg_n1 = W'(n1); cfg_n2 = W'(n2);
         end else begin
            cfg_n1 = W'($urandom_range(4095, 2)); cfg_n2 = W'($urandom_range(4095, 2));
         end
         send(1, k == 0, k == n1 * n2 - 1);
      end
   endtask

   task automatic flush();
      for (int i = 0; i < LAT + 3; i++) send(0, 0, 0);
   endtask

   initial begin
      cfg_n1 = '0; cfg_n2 = '0;
      in_valid = 0; in_sop = 0; in_eop = 0; in_real = '0; in_imag = '0;
      do_reset();

      frame(3, 4, 0);
      chk("den_3x4", 32'(denominator), 12);
      flush();

      frame(3, 4, 1);
      flush();

      frame(64, 64, 0);
      chk("last_num_64x64", 32'(numerator), 3969);
      chk("den_64x64_wrap", 32'(denominator), 0);

      // early eop on the 7th sample of a 3x4 frame
      cfg_n1 = 3; cfg_n2 = 4;
      send(1, 1, 0);
      for (int k = 1; k < 6; k++) send(1, 0, 0);
      send(1, 0, 1);
      chk("early_eop_err", 32'(err_frame), 1);
      frame(3, 4, 0);

      // sop arrives as the 5th sample of a running frame
      cfg_n1 = 3; cfg_n2 = 4;
      send(1, 1, 0);
      for (int k = 1; k < 4; k++) send(1, 0, 0);
      frame(3, 4, 0);

      // final index reached with no eop, then a stray sample in IDLE
      cfg_n1 = 2; cfg_n2 = 2;
      send(1, 1, 0);
      for (int k = 1; k < 4; k++) send(1, 0, 0);
      chk("no_eop_err", 32'(err_frame), 1);
      send(1, 0, 0);
      chk("idle_sample_num_held", 32'(numerator), 1);

      cfg_n1 = 5; cfg_n2 = 5;
      send(1, 1, 1);
      chk("sop_eop_err", 32'(err_frame), 1);
      flush();

      for (int f = 0; f < 8; f++) frame($urandom_range(9, 2), $urandom_range(9, 2), 2);
      flush();

      // reset while a frame is mid-flight
      cfg_n1 = 3; cfg_n2 = 4;
      send(1, 1, 0);
      for (int k = 1; k < 6; k++) send(1, 0, 0);
      do_reset();
      frame(3, 4, 1);
      flush();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/twdl_index_gen_cta.md
Name: twdl_index_gen_cta

Overview:
- Upstream feeder of the Cooley-Tukey twiddle coefficient generator. It sits between the row-ordered sample stream of an N1xN2 decomposition and the twiddle multiplier.
- For every input sample at (row r, column c) it produces numerator = r*c and denominator = N1*N2, which drive the exp(-j*2pi*num/den) coefficient generator.
- In parallel it delays the sample and its framing flags, so data leaves exactly when the matching coefficient does.

Parameters:
- wDataIn, 12, width of numerator/denominator and of N1/N2 (N1*N2 must fit in wDataIn bits).
- wData, 16, signed width of each I/Q sample.
- COEFF_DELAY, 24, latency in clk cycles of the downstream coefficient generator (numerator/denominator to cos/sin).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_n1  in  wDataIn  rows N1 (2..2^wDataIn-1), sampled at in_sop.
- cfg_n2  in  wDataIn  columns N2 (2..), sampled at in_sop.
- in_valid  in  1  sample strobe.
- in_sop  in  1  first sample of frame (qualified by in_valid).
- in_eop  in  1  last sample of frame (qualified by in_valid).
- in_real  in  wData  signed I.
- in_imag  in  wData  signed Q.
- numerator  out  wDataIn  r*c for the current sample.
- denominator  out  wDataIn  N1*N2 latched for the frame.
- out_valid, out_sop, out_eop  out  1 each  framing, aligned with out_real/out_imag.
- out_real, out_imag  out  wData  delayed samples.
- err_frame  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, counters 0, FSM in IDLE, delay-line contents and valid bits cleared.
- FSM states:
  - IDLE: waits for in_valid&in_sop.
  - RUN: a frame is in progress.
- Transitions:
  - IDLE->RUN on valid sop. Latch N1, N2; denominator <= N1*N2 (one registered multiply).
  - RUN->IDLE on valid eop with c==N2-1 and r==N1-1.
- Counters, advanced only on in_valid:
  - c: column 0..N2-1. r: row 0..N1-1. acc = r*c, built additively with no multiplier.
  - At row start (c=0): acc=0.
  - Otherwise acc <= acc + r.
  - When c wraps, r increments.
  - Sop sample: r=c=acc=0.
- numerator/denominator: registered, updated one cycle after an in_valid sample; held on in_valid=0 cycles.
- Bound: acc max (N1-1)(N2-1) < N1*N2, so no modulo reduction is needed.
- Data path: valid/sop/eop/real/imag pass through a fixed shift register of depth COEFF_DELAY+1, clocked every cycle regardless of valid.
  - Gaps are preserved.
  - out_* for a sample appear exactly COEFF_DELAY cycles after its numerator, the same cycle the coefficient appears.
- Error cases (err_frame=1 for one cycle in each):
  - Sop while in RUN: abort the frame and restart at the new sop (counters zeroed, N re-latched).
  - Eop in RUN before the final index: go to IDLE.
  - Final index reached without eop: go to IDLE.
  - Valid non-sop sample in IDLE: ignored; numerator is not updated; the data still passes through the delay line.
- Simultaneous sop&eop on one sample: treated as sop followed by early eop. Behaviour: err_frame, FSM returns to IDLE.
- cfg_n1/cfg_n2 changes mid-frame: ignored until the next sop.
- Reset mid-frame: everything clears asynchronously. Samples already in the delay line are discarded (out_valid=0).

Decomposition:
- Shared package twdl_cta_pkg holds:
  - wDataIn and wData defaults.
  - COEFF_DELAY.
  - FSM enum {IDLE, RUN}.
  - A packed struct of sample+flags, used as the delay-line element.
- One natural sub-module: twdl_delay_line, a parameterised depth x width shift register with async reset.
- The index counter/FSM stays in the top module.

Test Plan:
- N1=3,N2=4, continuous 12-sample frame:
  - numerator = 0,0,0,0, 0,1,2,3, 0,2,4,6.
  - denominator = 12.
  - out_sop 25 cycles after input sop; out_eop 25 cycles after input eop; err_frame never asserts.
- Same frame with in_valid low every other cycle:
  - Same numerator sequence, each value held across gap cycles.
  - out_valid pattern is identical to in_valid delayed 25 cycles.
- Max size N1=64,N2=64 (wDataIn=12):
  - Last numerator = 3969.
  - denominator = 4096 wraps to 0 in 12 bits; legal configurations must keep N1*N2<=4095.
- Early eop at sample 7 of a 3x4 frame: err_frame pulses, FSM returns to IDLE, and the next sop frame produces the correct sequence from 0.
- Sop at sample 5 of a running frame: err_frame pulses, counters restart, and the following numerators are 0,0,0,0,0,1,...
- rst_n pulsed low mid-frame: all outputs read 0 immediately, out_valid stays 0 for 25 cycles, and a new frame then works normally.
